header_builder: RTL and testbench

HEADER_BUILDER -- requirements
Module: header_builder

---
 rtl/header_builder.sv | 218 +++++++++++++++++++++
 tb/tb_header_builder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_builder.sv
// Builds a 512-bit Ethernet/IPv4/TCP-or-UDP header beat followed by N payload beats on AXI4-Stream.
// Optional macro HEADER_BUILDER_IP_CSUM_EN adds a one-cycle CSUM state that fills in the IPv4 header checksum.
module header_builder #(
  parameter int C_M_AXIS_DATA_WIDTH = 512
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [47:0]                          req_dst_mac,
  input  logic [47:0]                          req_src_mac,
  input  logic [95:0]                          req_flow_id,
  input  logic                                 req_is_udp,
  input  logic [15:0]                          req_window,
  input  logic                                 req_syn,
  input  logic                                 req_fin,
  input  logic [7:0]                           req_payload_beats,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_tkeep,
  output logic                                 m_tvalid,
  output logic                                 m_tlast,
  input  logic                                 m_tready,
  output logic [31:0]                          pkt_count
);

  localparam int unsigned DATA_W = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned KEEP_W = DATA_W / 8;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [95:0] flow_id;
    logic        is_udp;
    logic [15:0] window;
    logic        syn;
    logic        fin;
    logic [7:0]  beats;
  } req_t;

`ifdef HEADER_BUILDER_IP_CSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_CSUM, S_HEADER, S_PAYLOAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;
`endif

  state_t      state, next_state;
  req_t        req_in, hdr_src;
  logic [15:0] hdr_csum;
  logic [7:0]  beats_q, beat;
  logic        hs, accept, load_hdr, start_pay, next_pay, done;

  // IPv4 total length for one header beat plus n payload beats, minus the 14-byte Ethernet header
  function automatic logic [15:0] ip_len(input logic [7:0] n);
    return 16'((17'(n) + 17'd1) * 17'd64 - 17'd14);
  endfunction

  function automatic logic [DATA_W-1:0] build_header(input req_t r, input logic [15:0] csum);
    logic [7:0]        b [KEEP_W];
    logic [15:0]       len, udp_len;
    logic [DATA_W-1:0] d;
    for (int k = 0; k < KEEP_W; k++) b[k] = 8'h00;
    len     = ip_len(r.beats);
    udp_len = len - 16'd20;
    for (int k = 0; k < 6; k++) begin
      b[k]     = r.dst_mac[8*(5-k) +: 8];
      b[6 + k] = r.src_mac[8*(5-k) +: 8];
    end
    b[12] = 8'h08;
    b[14] = 8'h45;
    b[16] = len[15:8];
    b[17] = len[7:0];
    b[22] = 8'h40;
    b[23] = r.is_udp ? 8'h11 : 8'h06;
    b[24] = csum[15:8];
    b[25] = csum[7:0];
    for (int k = 0; k < 12; k++) b[26 + k] = r.flow_id[8*(11-k) +: 8];
    if (r.is_udp) begin
      b[38] = udp_len[15:8];
      b[39] = udp_len[7:0];
    end else begin
      b[46] = 8'h50;
      b[47] = {6'b0, r.syn, r.fin};
      b[48] = r.window[15:8];
      b[49] = r.window[7:0];
    end
    for (int k = 0; k < KEEP_W; k++) d[8*k +: 8] = b[k];
    return d;
  endfunction

  assign req_in = '{dst_mac: req_dst_mac, src_mac: req_src_mac, flow_id: req_flow_id,
                    is_udp: req_is_udp, window: req_window, syn: req_syn, fin: req_fin,
                    beats: req_payload_beats};

`ifdef HEADER_BUILDER_IP_CSUM_EN
  req_t req_q;

  // Ones-complement sum over the ten 16-bit IPv4 header words with the checksum word as zero
  function automatic logic [15:0] ip_csum(input req_t r);
    logic [31:0] sum;
    sum = 32'h0000_4500 + 32'(ip_len(r.beats)) + {16'h0, 8'h40, (r.is_udp ? 8'h11 : 8'h06)}
        + 32'(r.flow_id[95:80]) + 32'(r.flow_id[79:64])
        + 32'(r.flow_id[63:48]) + 32'(r.flow_id[47:32]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    return ~sum[15:0];
  endfunction

  assign hdr_src  = req_q;
  assign hdr_csum = ip_csum(req_q);
`else
  // Header is built straight from the request so it is valid the cycle after acceptance
  assign hdr_src  = req_in;
  assign hdr_csum = 16'h0000;
`endif

  assign m_tkeep = '1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_hdr   = 1'b0;
    start_pay  = 1'b0;
    next_pay   = 1'b0;
    done       = 1'b0;
    hs         = m_tvalid && m_tready;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
`ifdef HEADER_BUILDER_IP_CSUM_EN
          next_state = S_CSUM;
`else
          next_state = S_HEADER;
          load_hdr   = 1'b1;
`endif
        end
      end
`ifdef HEADER_BUILDER_IP_CSUM_EN
      S_CSUM: begin
        next_state = S_HEADER;
        load_hdr   = 1'b1;
      end
`endif
      S_HEADER: begin
        if (hs) begin
          if (beats_q != 8'd0) begin
            next_state = S_PAYLOAD;
            start_pay  = 1'b1;
          end else begin
            next_state = S_IDLE;
            done       = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (hs) begin
          if (m_tlast) begin
            next_state = S_IDLE;
            done       = 1'b1;
          end else begin
            next_pay = 1'b1;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output beat registers only change on load or handshake, so they hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
      pkt_count <= 32'd0;
      beats_q   <= 8'd0;
      beat      <= 8'd0;
`ifdef HEADER_BUILDER_IP_CSUM_EN
      req_q     <= '0;
`endif
    end else begin
      req_ready <= (next_state == S_IDLE);
      if (accept) begin
        beats_q <= req_payload_beats;
`ifdef HEADER_BUILDER_IP_CSUM_EN
        req_q   <= req_in;
`endif
      end
      if (load_hdr) begin
        m_tvalid <= 1'b1;
        m_tdata  <= build_header(hdr_src, hdr_csum);
        m_tlast  <= (hdr_src.beats == 8'd0);
      end
      if (start_pay) begin
        beat    <= 8'd0;
        m_tdata <= '0;
        m_tlast <= (beats_q == 8'd1);
      end
      if (next_pay) begin
        beat    <= beat + 8'd1;
        m_tdata <= {KEEP_W{beat + 8'd1}};
        m_tlast <= (beat + 8'd2 == beats_q);
      end
      if (done) begin
        m_tvalid  <= 1'b0;
        m_tlast   <= 1'b0;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_header_builder.sv
// Directed, table-driven bench for header_builder; honours HEADER_BUILDER_IP_CSUM_EN for latency and checksum.
module tb_header_builder;

`ifdef HEADER_BUILDER_IP_CSUM_EN
  localparam int EXP_LAT = 2;
  localparam int EXP_GAP = 3;
`else
  localparam int EXP_LAT = 1;
  localparam int EXP_GAP = 2;
`endif
  localparam logic [47:0] DST = 48'h0011_2233_4455;
  localparam logic [47:0] SRC = 48'h6677_8899_AABB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [47:0]  req_dst_mac = '0;
  logic [47:0]  req_src_mac = '0;
  logic [95:0]  req_flow_id = '0;
  logic         req_is_udp = 1'b0;
  logic [15:0]  req_window = '0;
  logic         req_syn = 1'b0;
  logic         req_fin = 1'b0;
  logic [7:0]   req_payload_beats = '0;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;
  logic [31:0]  pkt_count;

  always #5 clk = ~clk;

  header_builder #(.C_M_AXIS_DATA_WIDTH(512)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_mac(req_dst_mac), .req_src_mac(req_src_mac), .req_flow_id(req_flow_id),
    .req_is_udp(req_is_udp), .req_window(req_window), .req_syn(req_syn), .req_fin(req_fin),
    .req_payload_beats(req_payload_beats),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .pkt_count(pkt_count)
  );

  typedef struct {
    logic        is_udp;
    logic [7:0]  n;
    logic [95:0] flow;
    logic [15:0] window;
    logic        syn;
    logic        fin;
    logic [15:0] exp_len;
    logic [7:0]  exp_proto;
    logic [7:0]  exp_b47;
    logic [15:0] exp_l4;
    logic [15:0] exp_csum;
    logic        chk_csum;
  } vec_t;

  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;
  int   exp_pkts = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byt(input logic [511:0] d, input int k);
    return d[8*k +: 8];
  endfunction

  task automatic drive_req(input vec_t v);
    req_dst_mac       = DST;
    req_src_mac       = SRC;
    req_flow_id       = v.flow;
    req_is_udp        = v.is_udp;
    req_window        = v.window;
    req_syn           = v.syn;
    req_fin           = v.fin;
    req_payload_beats = v.n;
  endtask

  // Called on a negedge; returns on the negedge right after the accepting edge
  task automatic send_req(input vec_t v);
    int t;
    drive_req(v);
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 128'(req_ready), 128'(1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_pkt(input vec_t v, input string tag);
    int           lat, nbeats, last_idx, pay_bad, keep_bad, zero_bad;
    logic [511:0] hdr;
    logic [7:0]   pb;
    logic [47:0]  dm, sm;
    logic [95:0]  fl;
    logic [31:0]  s;
    send_req(v);
    lat = 1;
    while (!m_tvalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(EXP_LAT));
    hdr = m_tdata;
    nbeats = 0; last_idx = -1; pay_bad = 0; keep_bad = 0; zero_bad = 0;
    for (int c = 0; c < 400 && last_idx < 0; c++) begin
      if (m_tvalid) begin
        if (m_tkeep !== '1) keep_bad++;
        if (nbeats > 0) begin
          pb = 8'(nbeats - 1);
          if (m_tdata !== {64{pb}}) pay_bad++;
        end
        if (m_tlast) last_idx = nbeats;
        nbeats++;
      end
      @(negedge clk);
    end
    dm = '0; sm = '0; fl = '0;
    for (int k = 0; k < 6; k++) begin
      dm = {dm[39:0], byt(hdr, k)};
      sm = {sm[39:0], byt(hdr, 6 + k)};
    end
    for (int k = 26; k < 38; k++) fl = {fl[87:0], byt(hdr, k)};
    for (int k = 18; k < 22; k++) if (byt(hdr, k) != 8'h00) zero_bad++;
    for (int k = 38; k < 64; k++) begin
      if (v.is_udp && k >= 40 && byt(hdr, k) != 8'h00) zero_bad++;
      if (!v.is_udp && (k < 46 || k > 49) && byt(hdr, k) != 8'h00) zero_bad++;
    end
    check({tag, "_dst_mac"}, 128'(dm), 128'(DST));
    check({tag, "_src_mac"}, 128'(sm), 128'(SRC));
    check({tag, "_eth_ip"}, 128'({byt(hdr, 12), byt(hdr, 13), byt(hdr, 14), byt(hdr, 15)}), 128'(32'h0800_4500));
    check({tag, "_ip_len"}, 128'({byt(hdr, 16), byt(hdr, 17)}), 128'(v.exp_len));
    check({tag, "_ttl_proto"}, 128'({byt(hdr, 22), byt(hdr, 23)}), 128'({8'h40, v.exp_proto}));
    check({tag, "_flow"}, 128'(fl), 128'(v.flow));
`ifdef HEADER_BUILDER_IP_CSUM_EN
    if (v.chk_csum) check({tag, "_csum"}, 128'({byt(hdr, 24), byt(hdr, 25)}), 128'(v.exp_csum));
    s = 32'd0;
    for (int k = 14; k < 34; k += 2) s = s + {16'h0, byt(hdr, k), byt(hdr, k + 1)};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    check({tag, "_rx_csum"}, 128'(s[15:0]), 128'(16'hFFFF));
`else
    s = 32'd0;
    check({tag, "_csum"}, 128'({byt(hdr, 24), byt(hdr, 25)}), 128'(s[15:0]));
`endif
    if (v.is_udp) begin
      check({tag, "_udp_len"}, 128'({byt(hdr, 38), byt(hdr, 39)}), 128'(v.exp_l4));
    end else begin
      check({tag, "_tcp_off_flags"}, 128'({byt(hdr, 46), byt(hdr, 47)}), 128'({8'h50, v.exp_b47}));
      check({tag, "_tcp_window"}, 128'({byt(hdr, 48), byt(hdr, 49)}), 128'(v.exp_l4));
    end
    check({tag, "_zero_bytes"}, 128'(zero_bad), 128'(0));
    check({tag, "_tkeep"}, 128'(keep_bad), 128'(0));
    check({tag, "_payload"}, 128'(pay_bad), 128'(0));
    check({tag, "_tlast_pos"}, 128'(last_idx), 128'(v.n));
    check({tag, "_beats"}, 128'(nbeats), 128'(32'(v.n) + 32'd1));
    exp_pkts++;
    check({tag, "_idle_after"}, 128'({m_tvalid, req_ready}), 128'(2'b01));
    check({tag, "_pkt_count"}, 128'(pkt_count), 128'(exp_pkts));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   nl, prev, gap_bad, extra;
    int   hs, last_hs, stable_bad, rr_bad, idx, lseen;
    logic prev_v, prev_r, prev_l;
    logic [511:0] prev_d;

    vecs[0] = '{1'b0, 8'd0,   96'h01020304_05060708_1111_2222, 16'h1234, 1'b1, 1'b0,
                16'h0032, 8'h06, 8'h02, 16'h1234, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 8'd3,   96'h0A000001_0A000002_1F90_0050, 16'hBEEF, 1'b1, 1'b1,
                16'h00F2, 8'h11, 8'h00, 16'h00DE, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 8'd1,   96'hAC100001_AC100002_C000_01BB, 16'hFFFF, 1'b0, 1'b1,
                16'h0072, 8'h06, 8'h01, 16'hFFFF, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 8'd255, 96'h0B0C0D0E_0F101112_ABCD_EF01, 16'h0000, 1'b0, 1'b0,
                16'h3FF2, 8'h11, 8'h00, 16'h3FDE, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 8'd2,   96'h7F000001_7F000001_8000_0016, 16'hA5A5, 1'b1, 1'b1,
                16'h00B2, 8'h06, 8'h03, 16'hA5A5, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 8'd0,   96'hFFFFFFFF_00000000_0035_0035, 16'h0000, 1'b0, 1'b0,
                16'h0032, 8'h11, 8'h00, 16'h001E, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 8'd0,   96'hC0A80001_C0A80002_1234_0050, 16'h0100, 1'b0, 1'b0,
                16'h0032, 8'h06, 8'h00, 16'h0100, 16'hF972, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_valid_last", 128'({m_tvalid, m_tlast}), 128'(2'b00));
    check("rst_tdata", 128'(m_tdata[127:0] | m_tdata[511:384]), 128'(0));
    check("rst_pkt_count", 128'(pkt_count), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 128'(req_ready), 128'(1));

    // Ten back-to-back single-beat packets with req_valid held high
    drive_req(vecs[0]);
    req_valid = 1'b1;
    nl = 0; prev = 0; gap_bad = 0; extra = 0;
    for (int c = 0; c < 200 && nl < 10; c++) begin
      if (m_tvalid && m_tready) begin
        if (!m_tlast) extra++;
        else begin
          if (nl > 0 && c - prev != EXP_GAP) gap_bad++;
          prev = c;
          nl++;
          if (nl == 10) req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    exp_pkts = 10;
    check("b2b_tlast_count", 128'(nl), 128'(10));
    check("b2b_gap", 128'(gap_bad), 128'(0));
    check("b2b_non_last_beats", 128'(extra), 128'(0));
    check("b2b_pkt_count", 128'(pkt_count), 128'(10));

    foreach (vecs[i]) run_pkt(vecs[i], $sformatf("vec%0d", i));

    // Stall: m_tready toggles every cycle on an N=2 packet
    v = vecs[1];
    v.n = 8'd2;
    send_req(v);
    m_tready = 1'b0;
    hs = 0; last_hs = 0; stable_bad = 0; rr_bad = 0;
    prev_v = 1'b0; prev_r = 1'b1; prev_l = 1'b0; prev_d = '0;
    for (int c = 0; c < 80 && last_hs == 0; c++) begin
      if (prev_v && !prev_r && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l))
        stable_bad++;
      if (req_ready) rr_bad++;
      if (m_tvalid && m_tready) begin
        hs++;
        if (m_tlast) last_hs = hs;
      end
      prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata; prev_l = m_tlast;
      @(negedge clk);
      m_tready = ~m_tready;
    end
    m_tready = 1'b1;
    exp_pkts++;
    check("stall_stable", 128'(stable_bad), 128'(0));
    check("stall_req_ready_low", 128'(rr_bad), 128'(0));
    check("stall_handshakes", 128'(hs), 128'(3));
    check("stall_tlast_beat", 128'(last_hs), 128'(3));
    check("stall_valid_after", 128'(m_tvalid), 128'(0));
    check("stall_pkt_count", 128'(pkt_count), 128'(exp_pkts));

    // Reset while payload beat 1 of an N=5 packet is on the bus
    v = vecs[4];
    v.n = 8'd5;
    send_req(v);
    idx = 0; lseen = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_tvalid) begin
        if (idx == 2) break;
        if (m_tlast) lseen++;
        idx++;
      end
      @(negedge clk);
    end
    check("mid_payload_beat1", 128'({m_tvalid, byt(m_tdata, 0), byt(m_tdata, 63)}), 128'({1'b1, 8'h01, 8'h01}));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 128'({m_tvalid, m_tlast}), 128'(2'b00));
    check("mid_rst_no_tlast", 128'(lseen), 128'(0));
    check("mid_rst_pkt_count", 128'(pkt_count), 128'(0));
    check("mid_rst_req_ready", 128'(req_ready), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_req_ready", 128'(req_ready), 128'(1));
    exp_pkts = 0;
    run_pkt(vecs[2], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
